booth_mult_seq_ctrl: RTL



---
 rtl/booth_pkg.sv | 54 +++++
 rtl/booth_mult_seq_ctrl_if.sv | 23 ++
 rtl/booth_select.sv | 33 +++
 rtl/booth_mult_seq_ctrl.sv | 108 ++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared types, sizes and the radix-8 group encoder for the sequential Booth
// mantissa multiplier.
package booth_pkg;

  localparam int unsigned N            = 23;
  localparam int unsigned OP_W         = N + 1;
  localparam int unsigned PP_W         = N + 3;
  localparam int unsigned PROD_W       = 2 * N + 2;
  localparam int unsigned ACC_W        = 2 * N + 5;
  localparam int unsigned BOOTH_GROUPS = 9;

  typedef enum logic [1:0] {
    IDLE,
    PRECOMP,
    ITER,
    DONE
  } t_ctrl_state;

  // code is the multiple magnitude 0..4 (0, X, 2X, 3X, 4X)
  typedef struct packed {
    logic       sign;
    logic [2:0] code;
  } t_enc_out;

  typedef struct packed {
    logic            sign;
    logic [PP_W-1:0] pp_bits;
  } t_bs_comp_out;

  function automatic t_enc_out booth_encode(input logic [3:0] grp);
    t_enc_out e;
    e = '0;
    case (grp)
      4'b0000: e = '{sign: 1'b0, code: 3'd0};
      4'b0001: e = '{sign: 1'b0, code: 3'd1};
      4'b0010: e = '{sign: 1'b0, code: 3'd1};
      4'b0011: e = '{sign: 1'b0, code: 3'd2};
      4'b0100: e = '{sign: 1'b0, code: 3'd2};
      4'b0101: e = '{sign: 1'b0, code: 3'd3};
      4'b0110: e = '{sign: 1'b0, code: 3'd3};
      4'b0111: e = '{sign: 1'b0, code: 3'd4};
      4'b1000: e = '{sign: 1'b1, code: 3'd4};
      4'b1001: e = '{sign: 1'b1, code: 3'd3};
      4'b1010: e = '{sign: 1'b1, code: 3'd3};
      4'b1011: e = '{sign: 1'b1, code: 3'd2};
      4'b1100: e = '{sign: 1'b1, code: 3'd2};
      4'b1101: e = '{sign: 1'b1, code: 3'd1};
      4'b1110: e = '{sign: 1'b1, code: 3'd1};
      default: e = '{sign: 1'b0, code: 3'd0};
    endcase
    return e;
  endfunction

endpackage

// File: rtl/booth_mult_seq_ctrl_if.sv
// Operand/product valid-ready bundle for booth_mult_seq_ctrl.
// master = producer/consumer side, slave = the multiplier controller.
interface booth_mult_seq_ctrl_if;

  logic                        in_valid;
  logic                        in_ready;
  logic [booth_pkg::OP_W-1:0]  i_mant_a;
  logic [booth_pkg::OP_W-1:0]  i_mant_b;
  logic                        out_valid;
  logic                        out_ready;
  logic [booth_pkg::PROD_W-1:0] o_product;

  modport master (
    output in_valid, i_mant_a, i_mant_b, out_ready,
    input  in_ready, out_valid, o_product
  );

  modport slave (
    input  in_valid, i_mant_a, i_mant_b, out_ready,
    output in_ready, out_valid, o_product
  );

endinterface

// File: rtl/booth_select.sv
// Selects the Booth multiple for one group and 1's-complements it for
// negative selections; the +1 is added by the accumulator.
module booth_select
  import booth_pkg::*;
(
  input  logic [OP_W-1:0] mant_x_i,
  input  logic [PP_W-1:0] x3_i,
  input  t_enc_out        enc_i,
  output t_bs_comp_out    comp_o
);

  logic [PP_W-1:0] x1;
  logic [PP_W-1:0] x2;
  logic [PP_W-1:0] x4;
  logic [PP_W-1:0] mag;

  always_comb begin
    x1  = PP_W'(mant_x_i);
    x2  = x1 << 1;
    x4  = x1 << 2;
    mag = '0;
    case (enc_i.code)
      3'd1:    mag = x1;
      3'd2:    mag = x2;
      3'd3:    mag = x3_i;
      3'd4:    mag = x4;
      default: mag = '0;
    endcase
    comp_o.sign    = enc_i.sign;
    comp_o.pp_bits = enc_i.sign ? ~mag : mag;
  end

endmodule

// File: rtl/booth_mult_seq_ctrl.sv
// Sequential radix-8 Booth mantissa multiplier controller: one group per cycle.
// Optional BOOTH_CTRL_ZERO_SKIP_EN short-circuits zero operands straight to DONE.
module booth_mult_seq_ctrl
  import booth_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  booth_mult_seq_ctrl_if.slave        io,
  output logic                        o_busy
);

  t_ctrl_state       state_q, state_d;
  logic [OP_W-1:0]   x_q, x_d;
  logic [OP_W-1:0]   y_q, y_d;
  logic [PP_W-1:0]   x3_q, x3_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [3:0]        j_q, j_d;

  logic [OP_W+3:0]   y_ext;
  logic [4:0]        shamt;
  logic [3:0]        grp;
  t_enc_out          enc;
  t_bs_comp_out      comp;
  logic [ACC_W-1:0]  pp_ext;

  // y[-1]=0 at bit 0, three zero bits above the MSB for the last group
  assign y_ext = {3'b000, y_q, 1'b0};
  assign shamt = {1'b0, j_q} * 5'd3;
  assign grp   = y_ext[shamt +: 4];
  assign enc   = booth_encode(grp);

  booth_select u_sel (
    .mant_x_i (x_q),
    .x3_i     (x3_q),
    .enc_i    (enc),
    .comp_o   (comp)
  );

  // Multiples are unsigned, so the extension comes from the selection sign
  // rather than from the top bit of the 26-bit field (4X can reach bit 25).
  assign pp_ext = {{(ACC_W-PP_W){comp.sign}}, comp.pp_bits};

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    x3_d    = x3_q;
    acc_d   = acc_q;
    j_d     = j_q;
    case (state_q)
      IDLE: begin
        if (io.in_valid) begin
          x_d   = io.i_mant_a;
          y_d   = io.i_mant_b;
          acc_d = '0;
          j_d   = '0;
`ifdef BOOTH_CTRL_ZERO_SKIP_EN
          state_d = ((io.i_mant_a == '0) || (io.i_mant_b == '0)) ? DONE : PRECOMP;
`else
          state_d = PRECOMP;
`endif
        end
      end
      PRECOMP: begin
        x3_d    = PP_W'(x_q) + (PP_W'(x_q) << 1);
        state_d = ITER;
      end
      ITER: begin
        acc_d = acc_q + (pp_ext << shamt) + (ACC_W'(comp.sign) << shamt);
        if (j_q == 4'(BOOTH_GROUPS - 1)) begin
          j_d     = '0;
          state_d = DONE;
        end else begin
          j_d = j_q + 4'd1;
        end
      end
      DONE: begin
        if (io.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      x3_q    <= '0;
      acc_q   <= '0;
      j_q     <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      x3_q    <= x3_d;
      acc_q   <= acc_d;
      j_q     <= j_d;
    end
  end

  // Product is gated so intermediate accumulator values never appear.
  assign io.in_ready  = (state_q == IDLE);
  assign io.out_valid = (state_q == DONE);
  assign io.o_product = (state_q == DONE) ? acc_q[PROD_W-1:0] : '0;
  assign o_busy       = (state_q != IDLE);

endmodule
